// File: rtl/sobel_stream_ctrl_if.sv
// Stream-side signals of the sobel sequencer: input FIFO pop, window shift, sobel magnitude, output FIFO push.
// The master modport is the sequencer; the slave modport is the FIFO/datapath side.
interface sobel_stream_ctrl_if #(
  parameter int DWIDTH = 8
);
  logic              fifo_in_rd_en;
  logic [DWIDTH-1:0] fifo_in_dout;
  logic              fifo_in_empty;
  logic              win_shift_en;
  logic [DWIDTH-1:0] win_din;
  logic [DWIDTH-1:0] sobel_mag;
  logic              fifo_out_wr_en;
  logic [DWIDTH-1:0] fifo_out_din;
  logic              fifo_out_full;

  modport master (
    output fifo_in_rd_en, win_shift_en, win_din, fifo_out_wr_en, fifo_out_din,
    input  fifo_in_dout, fifo_in_empty, sobel_mag, fifo_out_full
  );

  modport slave (
    input  fifo_in_rd_en, win_shift_en, win_din, fifo_out_wr_en, fifo_out_din,
    output fifo_in_dout, fifo_in_empty, sobel_mag, fifo_out_full
  );
endinterface

// File: rtl/sobel_stream_ctrl.sv
// Prime/run/flush sequencer for the sobel 3x3 window datapath; one output pixel per input pixel.
// Define SOBEL_BORDER_ZERO_EN to force output pixels on the frame border to zero.
module sobel_stream_ctrl #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540,
  parameter int DWIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  sobel_stream_ctrl_if.master io,
  output logic                busy,
  output logic                frame_done
);
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int NPRIME = WIDTH + 1;
  localparam int NRUN   = NPIX - NPRIME;
  localparam int CW     = $clog2(NPIX);
  localparam int XW     = $clog2(WIDTH);
  localparam int YW     = $clog2(HEIGHT);

  typedef enum logic [1:0] {PRIME, RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] out_x_q, out_x_d;
  logic [YW-1:0] out_y_q, out_y_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  logic              src_ok, step, wr, produce, phase_last, x_last, y_last;
  logic [DWIDTH-1:0] mag_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= PRIME;
      cnt_q        <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    // Handshakes are held off during reset so an abandoned frame never pushes or pops.
    src_ok  = (state_q == FLUSH) || !io.fifo_in_empty;
    step    = !reset && src_ok && (!out_valid_q || !io.fifo_out_full);
    wr      = !reset && out_valid_q && !io.fifo_out_full;
    produce = step && (state_q != PRIME);
    x_last  = (out_x_q == XW'(WIDTH - 1));
    y_last  = (out_y_q == YW'(HEIGHT - 1));

    phase_last = 1'b0;
    case (state_q)
      PRIME:   phase_last = (cnt_q == CW'(NPRIME - 1));
      RUN:     phase_last = (cnt_q == CW'(NRUN - 1));
      FLUSH:   phase_last = (cnt_q == CW'(NPRIME - 1));
      default: phase_last = 1'b1;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    if (step) begin
      if (phase_last) begin
        cnt_d = '0;
        case (state_q)
          PRIME:   state_d = RUN;
          RUN:     state_d = FLUSH;
          default: state_d = PRIME;
        endcase
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // A write and a new producing step in the same cycle keep the output slot occupied.
    out_valid_d  = produce || (out_valid_q && !wr);
    frame_done_d = wr && x_last && y_last;

    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (wr) begin
      if (x_last) begin
        out_x_d = '0;
        out_y_d = y_last ? '0 : out_y_q + YW'(1);
      end else begin
        out_x_d = out_x_q + XW'(1);
      end
    end
  end

`ifdef SOBEL_BORDER_ZERO_EN
  logic border;
  always_comb begin
    border  = (out_x_q == '0) || x_last || (out_y_q == '0) || y_last;
    mag_out = border ? '0 : io.sobel_mag;
  end
`else
  assign mag_out = io.sobel_mag;
`endif

  always_comb begin
    io.fifo_in_rd_en  = step && (state_q != FLUSH);
    io.win_shift_en   = step;
    io.win_din        = (state_q == FLUSH) ? '0 : io.fifo_in_dout;
    io.fifo_out_wr_en = wr;
    io.fifo_out_din   = mag_out;
  end

  assign busy       = (state_q != PRIME) || (cnt_q != '0);
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Randomized bench for sobel_stream_ctrl: FIFO and window models drive the DUT, and every output
// pixel is scored against the popped pixel stream (border pixels zeroed when SOBEL_BORDER_ZERO_EN).
module tb_sobel_stream_ctrl;
  localparam int W = 4, H = 3, DW = 8, NPIX = W * H;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy, frame_done;

  sobel_stream_ctrl_if #(.DWIDTH(DW)) io ();

  sobel_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .DWIDTH(DW)) dut (
    .clock(clock), .reset(reset), .io(io), .busy(busy), .frame_done(frame_done));

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  logic [DW-1:0] inq[$];
  logic [DW-1:0] pix[$];
  logic [DW-1:0] win [W+2];
  logic [DW-1:0] ref_frame [NPIX];
  int  nw = 0, npops = 0, fd_cnt = 0, cyc = 0, pop_cyc = 0;
  bit  fd_exp = 0, lat_chk = 0, stall_chk = 0, idle_chk = 0, force_full = 0, tog = 0;
  int  empty_mode = 0, full_pct = 0;

  // Datapath stand-in: the window centre is the pixel shifted in WIDTH+1 shifts before the newest.
  assign io.sobel_mag = win[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    if (obs !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  // Output n since reset is centred on popped pixel n; its frame position is n mod frame size.
  function automatic logic [DW-1:0] expect_px(int n);
`ifdef SOBEL_BORDER_ZERO_EN
    int k, x, y;
    k = n % NPIX; x = k % W; y = k / W;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return '0;
`endif
    return pix[n];
  endfunction

  task automatic drive();
    bit gate;
    tog = ~tog;
    case (empty_mode)
      1:       gate = tog;
      2:       gate = ($urandom_range(0, 3) == 0);
      default: gate = 1'b0;
    endcase
    io.fifo_in_empty = (inq.size() == 0) || gate;
    io.fifo_in_dout  = (inq.size() != 0) ? inq[0] : DW'($urandom);
    io.fifo_out_full = force_full || (full_pct > 0 && $urandom_range(0, 99) < full_pct);
  endtask

  task automatic tick();
    logic rd, sh, wr, fd, rst_s, last;
    logic [DW-1:0] din, wd;
    @(negedge clock);
    cyc++;
    rd = io.fifo_in_rd_en; sh = io.win_shift_en; wr = io.fifo_out_wr_en;
    fd = frame_done; din = io.fifo_out_din; wd = io.win_din; rst_s = reset;
    last = 1'b0;
    chk("frame_done", fd, fd_exp);
    if (rd) begin
      chk("pop_when_empty", io.fifo_in_empty, 0);
      chk("pop_without_shift", sh, 1);
      chk("win_din", wd, io.fifo_in_dout);
    end
    if (sh && !rd) chk("flush_din", wd, 0);
    if (rst_s) begin chk("rst_wr", wr, 0); chk("rst_shift", sh, 0); end
    if (io.fifo_out_full) chk("wr_while_full", wr, 0);
    if (stall_chk) begin
      chk("stall_shift", sh, 0); chk("stall_pop", rd, 0); chk("stall_busy", busy, 1);
    end
    if (idle_chk) begin
      chk("idle_busy", busy, 0); chk("idle_wr", wr, 0);
      chk("idle_shift", sh, 0); chk("idle_pop", rd, 0); chk("idle_fd", fd, 0);
    end
    if (wr) begin
      chk("wr_has_source", nw < pix.size(), 1);
      if (nw < pix.size()) chk("wr_data", din, expect_px(nw));
      if (lat_chk && nw == 0) chk("first_wr_latency", cyc - pop_cyc, 1);
      last = (nw % NPIX) == NPIX - 1;
    end
    if (fd) fd_cnt++;
    @(posedge clock); #1;
    if (rd && inq.size() > 0) begin
      pix.push_back(inq.pop_front());
      npops++;
      if (npops == W + 2) pop_cyc = cyc;
    end
    if (sh) begin
      for (int i = 0; i < W + 1; i++) win[i] = win[i+1];
      win[W+1] = wd;
    end
    if (wr) nw++;
    fd_exp = wr && last && !rst_s;
    if (rst_s) begin pix.delete(); nw = 0; npops = 0; end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1; inq.delete(); force_full = 0; drive();
    repeat (2) tick();
    reset = 1'b0; drive();
    fd_cnt = 0;
    idle_chk = 1; tick(); idle_chk = 0;
  endtask

  task automatic load_ref();
    foreach (ref_frame[i]) inq.push_back(ref_frame[i]);
    drive();
  endtask

  task automatic load_rand();
    for (int i = 0; i < NPIX; i++) inq.push_back(DW'($urandom_range(1, 255)));
    drive();
  endtask

  task automatic run_frames(int nf, int budget);
    int c = 0;
    while (nw < nf * NPIX && c < budget) begin tick(); c++; end
    chk("wr_count", nw, nf * NPIX);
    repeat (W + 4) tick();
    chk("no_extra_wr", nw, nf * NPIX);
    chk("frame_done_count", fd_cnt, nf);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    foreach (win[i]) win[i] = '0;
    foreach (ref_frame[i]) ref_frame[i] = DW'($urandom_range(1, 255));
    drive();

    // Free-flowing single frame.
    do_reset(); lat_chk = 1;
    load_ref(); run_frames(1, 200);

    // Input FIFO empty every other cycle.
    do_reset(); empty_mode = 1;
    load_ref(); run_frames(1, 400);
    empty_mode = 0;

    // Output FIFO full for 5 cycles mid-RUN.
    do_reset(); load_rand();
    c = 0;
    while (nw < 3 && c < 200) begin tick(); c++; end
    chk("stall_setup_writes", nw, 3);
    force_full = 1; stall_chk = 1; drive();
    repeat (5) tick();
    force_full = 0; stall_chk = 0; drive();
    run_frames(1, 200);

    // Two back-to-back frames.
    do_reset(); load_rand(); load_rand(); run_frames(2, 400);

    // Reset after the 8th pop, then a fresh frame.
    do_reset(); load_ref();
    c = 0;
    while (npops < 8 && c < 200) begin tick(); c++; end
    chk("pre_reset_pops", npops, 8);
    do_reset(); load_ref(); run_frames(1, 200);

    // Random input gaps and output back-pressure across three frames.
    do_reset(); lat_chk = 0; empty_mode = 2; full_pct = 30;
    load_rand(); load_rand(); load_rand(); run_frames(3, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
